// File: rtl/instr_fetch_buffer_pkg.sv
// Fetch-path types shared by the fetcher, the fetch buffer and decode.
package instr_fetch_buffer_pkg;

    localparam int unsigned FETCH_XLEN = 64;

    typedef enum logic [3:0] {
        IF_PREFETCH     = 4'h0,
        IF_PREDICT      = 4'h1,
        IF_MISPREDICT   = 4'h2,
        IF_PROT_CHANGED = 4'h3,
        IF_SATP_CHANGED = 4'h4,
        IF_FENCE_I      = 4'h5
    } if_reason_e;

    typedef enum logic [3:0] {
        EXC_CAUSE_INSN_ADDR_MISA   = 4'd0,
        EXC_CAUSE_INSTR_ACCESS_FAULT = 4'd1,
        EXC_CAUSE_ILLEGAL_INSN     = 4'd2,
        EXC_CAUSE_BREAKPOINT       = 4'd3,
        EXC_CAUSE_INSTR_PAGE_FAULT = 4'd12
    } exc_cause_e;

    typedef struct packed {
        logic                  interrupt;
        exc_cause_e            cause;
        logic [FETCH_XLEN-1:0] tval;
    } exception_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        if_reason_e            if_reason;
        logic [31:0]           instr_word;
        logic                  ex_valid;
        exception_t            exception;
    } fetched_instr_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// Circular FIFO between instruction fetch and decode; a flush empties it in one cycle.
// Optional INSTR_FETCH_BUFFER_BYPASS_EN presents the incoming entry combinationally when empty.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  fetched_instr_t         in_instr_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output fetched_instr_t         out_instr_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("instr_fetch_buffer: DEPTH must be a power of two and at least 2");
    end
    if (XLEN != FETCH_XLEN) begin : g_xlen_chk
        $error("instr_fetch_buffer: XLEN must match the fetcher pc width");
    end

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    fetched_instr_t mem_q [DEPTH];
    fetched_instr_t mem_d [DEPTH];

    logic [IW-1:0]  wr_idx, rd_idx;
    logic           empty, full;
    logic           enq, deq;
    logic           bypass_valid, bypass_take;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];

    always_comb begin
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
        bypass_valid = 1'b0;
        bypass_take  = 1'b0;
`ifdef INSTR_FETCH_BUFFER_BYPASS_EN
        // An entry consumed straight through never touches storage.
        bypass_valid = empty && in_valid_i && !flush_i;
        bypass_take  = bypass_valid && out_ready_i;
`endif
        enq          = in_valid_i && !full && !flush_i && !bypass_take;
        deq          = !empty && !flush_i && out_ready_i;

        in_ready_o   = !full;
        out_valid_o  = (!empty || bypass_valid) && !flush_i;
        out_instr_o  = bypass_valid ? in_instr_i : mem_q[rd_idx];
        count_o      = wr_ptr_q - rd_ptr_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
        if (enq) mem_d[wr_idx] = in_instr_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end

`ifndef SYNTHESIS
    a_no_enq_full: assert property (@(posedge clk) disable iff (!resetn) enq |-> !full);
    a_no_deq_empty: assert property (@(posedge clk) disable iff (!resetn) deq |-> !empty);
    a_count_range: assert property (@(posedge clk) disable iff (!resetn) count_o <= DEPTH_P);
    a_out_stable: assert property (@(posedge clk) disable iff (!resetn)
        (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_instr_o));
`endif

endmodule
